// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake,
// registered instruction with opCode, redirect and stall handling.
module instr_fetch_unit #(
   parameter int                 ADDR_W   = 32,
   parameter int                 DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              stall,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [5:0]        opCode,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [31:0]       instr_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] fl_addr_q, fl_addr_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic              valid_q, valid_d;
   logic [31:0]       count_q, count_d;
   logic [ADDR_W-1:0] redir_pc;

   assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         fl_addr_q <= RESET_PC;
         instr_q   <= '0;
         pc_out_q  <= RESET_PC;
         valid_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         fl_addr_q <= fl_addr_d;
         instr_q   <= instr_d;
         pc_out_q  <= pc_out_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      fl_addr_d = fl_addr_q;
      instr_d   = instr_q;
      pc_out_d  = pc_out_q;
      valid_d   = valid_q;
      count_d   = count_q;
      unique case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            if (redirect_valid) begin
               pc_d = redir_pc;
               if (!imem_ack) begin
                  // keep the in-flight address until the ack
                  fl_addr_d = pc_q;
                  state_d   = FLUSH;
               end
            end else if (imem_ack) begin
               instr_d  = imem_rdata;
               pc_out_d = pc_q;
               valid_d  = 1'b1;
               state_d  = HOLD;
            end
         end
         FLUSH: begin
            if (redirect_valid) begin
               pc_d = redir_pc;
            end
            if (imem_ack) begin
               state_d = REQ;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_d    = redir_pc;
               valid_d = 1'b0;
               instr_d = '0;
               state_d = REQ;
            end else if (!stall) begin
               count_d = count_q + 32'd1;
               pc_d    = pc_out_q + ADDR_W'(4);
               valid_d = 1'b0;
               instr_d = '0;
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Memory request outputs
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc_q;
      if (state_q == REQ) begin
         imem_req = 1'b1;
      end else if (state_q == FLUSH) begin
         imem_req  = 1'b1;
         imem_addr = fl_addr_q;
      end
   end

   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign opCode      = instr_q[DATA_W-1 -: 6];
   assign pc_out      = pc_out_q;
   assign pc_plus4    = pc_out_q + ADDR_W'(4);
   assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
// Second instance checks PC wrap from 32'hFFFFFFFC.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stall = 1'b0;

   logic        imem_req, instr_valid;
   logic [31:0] imem_addr, instr, pc_out, pc_plus4, instr_count;
   logic [5:0]  opCode;

   logic        w_req, w_valid;
   logic [31:0] w_addr, w_instr, w_pc_out, w_pc_plus4, w_count;
   logic [5:0]  w_op;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall(stall), .instr_valid(instr_valid), .instr(instr),
      .opCode(opCode), .pc_out(pc_out), .pc_plus4(pc_plus4),
      .instr_count(instr_count)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall(stall), .instr_valid(w_valid), .instr(w_instr),
      .opCode(w_op), .pc_out(w_pc_out), .pc_plus4(w_pc_plus4),
      .instr_count(w_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] d;

   initial begin
      // reset values
      #1;
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_instr", instr, 0);
      chk("rst_op", 32'(opCode), 0);
      chk("rst_pcout", pc_out, 0);
      chk("rst_cnt", instr_count, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("idle_req", 32'(imem_req), 0);
      tick();

      // four back-to-back fetches, no stall
      for (int i = 0; i < 4; i++) begin
         d = (i == 0) ? 32'h8C000000 : 32'h10000000 * (i + 1) + i;
         chk("req", 32'(imem_req), 1);
         chk("addr", imem_addr, 32'(i * 4));
         if (i == 0) chk("wrap_addr0", w_addr, 32'hFFFFFFFC);
         if (i == 1) chk("wrap_addr1", w_addr, 32'h0);
         imem_ack = 1'b1;
         imem_rdata = d;
         tick();
         imem_ack = 1'b0;
         chk("valid", 32'(instr_valid), 1);
         chk("instr", instr, d);
         chk("op", 32'(opCode), 32'(d[31:26]));
         chk("pcout", pc_out, 32'(i * 4));
         chk("pcp4", pc_plus4, 32'(i * 4 + 4));
         chk("hold_req", 32'(imem_req), 0);
         tick();
         chk("valid_fall", 32'(instr_valid), 0);
         chk("op_zero", 32'(opCode), 0);
         chk("count", instr_count, 32'(i + 1));
      end
      chk("op_lw", 32'(6'b100011), 32'(6'h23));

      // stall held three cycles in HOLD
      chk("st_addr", imem_addr, 32'h10);
      imem_ack = 1'b1;
      imem_rdata = 32'hABCD1234;
      stall = 1'b1;
      tick();
      imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_valid", 32'(instr_valid), 1);
         chk("st_instr", instr, 32'hABCD1234);
         chk("st_op", 32'(opCode), 32'h2A);
         chk("st_pcout", pc_out, 32'h10);
         chk("st_req", 32'(imem_req), 0);
         chk("st_cnt", instr_count, 4);
      end
      stall = 1'b0;
      tick();
      chk("st_cnt_inc", instr_count, 5);
      chk("st_next", imem_addr, 32'h14);

      // redirect in REQ, ack delayed two cycles
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect_valid = 1'b0;
      chk("fl_req", 32'(imem_req), 1);
      chk("fl_addr", imem_addr, 32'h14);
      tick();
      chk("fl_addr2", imem_addr, 32'h14);
      imem_ack = 1'b1;
      imem_rdata = 32'hDEADBEEF;
      tick();
      imem_ack = 1'b0;
      chk("fl_valid", 32'(instr_valid), 0);
      chk("fl_new", imem_addr, 32'h40);
      chk("fl_newreq", 32'(imem_req), 1);

      // redirect and stall together in HOLD
      imem_ack = 1'b1;
      imem_rdata = 32'h20000001;
      tick();
      imem_ack = 1'b0;
      chk("rs_valid", 32'(instr_valid), 1);
      chk("rs_pcout", pc_out, 32'h40);
      stall = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h103;
      tick();
      stall = 1'b0;
      redirect_valid = 1'b0;
      chk("rs_vfall", 32'(instr_valid), 0);
      chk("rs_cnt", instr_count, 5);
      chk("rs_addr", imem_addr, 32'h100);

      // redirect and ack in same REQ cycle
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      imem_ack = 1'b1;
      imem_rdata = 32'h55555555;
      tick();
      redirect_valid = 1'b0;
      imem_ack = 1'b0;
      chk("ra_valid", 32'(instr_valid), 0);
      chk("ra_addr", imem_addr, 32'h200);
      chk("ra_req", 32'(imem_req), 1);

      // reset while request pending
      #2 rst_n = 1'b0;
      #1;
      chk("mr_req", 32'(imem_req), 0);
      chk("mr_valid", 32'(instr_valid), 0);
      chk("mr_cnt", instr_count, 0);
      chk("mr_pcout", pc_out, 0);
      chk("mr_instr", instr, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'h77777777;
      chk("mr_idle", 32'(imem_req), 0);
      tick();
      imem_ack = 1'b0;
      chk("mr_ignack", 32'(instr_valid), 0);
      chk("mr_req2", 32'(imem_req), 1);
      chk("mr_addr", imem_addr, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of control_unit.
- Holds the PC and issues word requests to instruction memory through a req/ack handshake.
- Registers each returned instruction and presents it, with its opCode field (instr[31:26]), to control_unit and the rest of decode.
- Accepts branch/jump redirects from execute, and stalls from downstream.

Parameters:
- ADDR_W, 32, PC / instruction-memory byte-address width
- DATA_W, 32, instruction width
- RESET_PC, 32'h00000000, first fetch address after reset

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  ADDR_W  fetch byte address, word aligned
- imem_ack  input  1  memory response; imem_rdata is valid in the same cycle
- imem_rdata  input  DATA_W  fetched instruction word
- redirect_valid  input  1  branch taken or jump; single-cycle pulse
- redirect_pc  input  ADDR_W  redirect target
- stall  input  1  decode cannot accept the held instruction this cycle
- instr_valid  output  1  instr, opCode and pc_out are valid
- instr  output  DATA_W  registered instruction
- opCode  output  6  instr[31:26], drives control_unit opCode
- pc_out  output  ADDR_W  address of the held instruction
- pc_plus4  output  ADDR_W  pc_out + 4, used for branch/jump target computation
- instr_count  output  32  number of instructions consumed by decode

Behaviour:
- Reset (async, rst_n=0), applied immediately:
  - state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, opCode=0, pc_out=RESET_PC, instr_count=0.
- States: IDLE, REQ, HOLD, FLUSH.
- IDLE: lasts one cycle after reset release, then goes to REQ. imem_ack is ignored in IDLE.
- REQ:
  - imem_req=1 and imem_addr=pc; both stay stable until imem_ack.
  - Ack with no redirect: instr<=imem_rdata, pc_out<=pc, instr_valid<=1, go to HOLD. Minimum fetch latency is 1 cycle from req to valid.
  - Redirect with no ack: pc<=redirect_pc, go to FLUSH. The request stays asserted at the old address, because the address must not change mid-handshake.
  - Redirect and ack in the same cycle: discard rdata, pc<=redirect_pc, stay in REQ. The new address is presented on the next cycle.
- FLUSH:
  - imem_req=1 at the old address until ack.
  - On ack: discard data, go to REQ at the new pc.
  - A further redirect in FLUSH overwrites the pending pc, and the latest redirect wins.
- HOLD: instr_valid=1; instr, opCode and pc_out are held stable.
  - redirect_valid has priority over stall: instr_valid<=0, pc<=redirect_pc, go to REQ. The held instruction is dropped and not counted.
  - Otherwise, stall=1: remain in HOLD with no change.
  - Otherwise, stall=0: the instruction is consumed this cycle. Then instr_count<=instr_count+1, pc<=pc_out+4, instr_valid<=0, go to REQ.
- imem_req=0 in IDLE and HOLD.
- Arithmetic:
  - pc+4 is modulo 2^ADDR_W, so 32'hFFFFFFFC wraps to 0.
  - redirect_pc[1:0] is forced to 00 on capture.
  - instr_count wraps at 2^32.
- opCode is combinational from registered instr. It reads 0 whenever instr_valid=0, because instr is cleared when valid falls. Consumers gate on instr_valid.
- Reset mid-handshake: the fetch is abandoned. Instruction memory shares rst_n, and any ack arriving in IDLE is ignored.
- redirect_valid in IDLE is ignored.

Test Plan:
- Reset release, memory acks 1 cycle after each req, stall=0:
  - Addresses issued are 0,4,8,C.
  - Each instruction is valid for exactly 1 cycle.
  - opCode follows rdata[31:26]; for example, rdata=32'h8C000000 gives opCode=6'b100011.
  - instr_count=4 after the fourth consume.
- Stall held 3 cycles in HOLD:
  - instr, pc_out and opCode stay stable for those cycles.
  - No new imem_req.
  - instr_count increments only on the cycle stall drops.
- Redirect in REQ with ack delayed 2 cycles (redirect_pc=32'h40):
  - Old address stays on imem_addr until ack.
  - That data is discarded, with no instr_valid.
  - The next request is at 32'h40.
- Redirect and stall together in HOLD (redirect_pc=32'h103):
  - instr_valid falls next cycle and instr_count is unchanged.
  - Next imem_addr=32'h100.
- Wrap: RESET_PC=32'hFFFFFFFC, consume one instruction -> next imem_addr=32'h00000000.
- rst_n asserted while imem_req=1 and ack pending -> all outputs return to reset values immediately. After release: one IDLE cycle, then a request at RESET_PC.
